// File: rtl/lisp_eval_unit.sv
// lisp_eval_unit -- iterative evaluator for number atoms and nested primitive
// applications (+, -, optionally *) stored as heap cells.
//
// Build option: define LISP_EVAL_MUL_EN to enable opcode 2 (multiply).
// Without it, no multiplier is built and opcode 2 raises APPLY_ERROR.
//
// Cell layout at address A: header at A, car at A-1, cdr at A-2.
// Argument lists are chains of cells: car = argument expression, cdr = rest.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_expr_in  request pulse (sampled in Idle) and expression pointer
//   o_busy              evaluation in progress
//   o_done / o_result   one-cycle completion pulse, result word (held)
//   o_err / o_error_code one-cycle error pulse, error code (held)
//   o_mem_req/o_mem_addr one-cycle heap read request and address
//   i_mem_ready/i_mem_data read response pulse and data

package lisp_defs;
  localparam int LISP_NIL       = 0;
  localparam int TYPE_NUMBER    = 1;
  localparam int TYPE_CONS      = 2;
  localparam int TYPE_PRIMITIVE = 3;
  localparam logic [15:0] EVAL_ERROR  = 16'hBBBB;
  localparam logic [15:0] APPLY_ERROR = 16'hCCCC;
  localparam logic [15:0] STACK_ERROR = 16'hDDDD;
endpackage

module lisp_eval_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_expr_in,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [DATA_W-1:0] o_result,
  output logic [15:0]       o_error_code,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_data
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH_HDR = 4'd1;
  localparam logic [3:0] S_FETCH_CAR = 4'd2;
  localparam logic [3:0] S_FETCH_CDR = 4'd3;
  localparam logic [3:0] S_MEM_WAIT  = 4'd4;
  localparam logic [3:0] S_EVAL      = 4'd5;
  localparam logic [3:0] S_APPLY     = 4'd6;
  localparam logic [3:0] S_NEXT_ARG  = 4'd7;
  localparam logic [3:0] S_RETURN    = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;
  localparam logic [3:0] S_ERROR     = 4'd10;

  // Which word the pending read returns.
  localparam logic [1:0] W_HDR = 2'd0;
  localparam logic [1:0] W_CAR = 2'd1;
  localparam logic [1:0] W_CDR = 2'd2;

  // Why the current cell is being fetched; selects the post-fetch state.
  localparam logic [1:0] M_EXPR = 2'd0;  // expression to evaluate
  localparam logic [1:0] M_OP   = 2'd1;  // operator cell of an application
  localparam logic [1:0] M_ARG  = 2'd2;  // argument-list cell

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  localparam logic [DATA_W-1:0] NIL = DATA_W'(lisp_defs::LISP_NIL);

  logic [3:0]        r_state;
  logic [1:0]        r_ret;
  logic [1:0]        r_mode;
  logic [ADDR_W-1:0] r_cell;
  logic [DATA_W-2:0] r_type;
  logic [DATA_W-1:0] r_car;
  logic [DATA_W-1:0] r_cdr;
  logic [DATA_W-1:0] r_val;
  logic [DATA_W-1:0] r_pend;     // arg list of the application awaiting its operator
  logic [SP_W-1:0]   r_sp;
  logic [DATA_W-1:0] r_result;
  logic [15:0]       r_err_code;

  // Frame stack (contents need no reset; r_sp defines what is live).
  logic [1:0]        r_op   [STACK_DEPTH];
  logic [DATA_W-1:0] r_acc  [STACK_DEPTH];
  logic [1:0]        r_argc [STACK_DEPTH];  // saturates at 2: only 0/1/many matter
  logic [DATA_W-1:0] r_args [STACK_DEPTH];

  logic [IDX_W-1:0]  w_top;
  logic [IDX_W-1:0]  w_push;
  logic [DATA_W-1:0] w_comb;
  logic [DATA_W-1:0] w_pop_val;
  logic              w_op_ok;
  logic              w_is_num;
  logic              w_is_cons;
  logic              w_is_prim;

  assign w_top  = IDX_W'(r_sp - SP_W'(1));
  assign w_push = IDX_W'(r_sp);

  assign w_is_num  = (r_type == (DATA_W-1)'(lisp_defs::TYPE_NUMBER));
  assign w_is_cons = (r_type == (DATA_W-1)'(lisp_defs::TYPE_CONS));
  assign w_is_prim = (r_type == (DATA_W-1)'(lisp_defs::TYPE_PRIMITIVE));

`ifdef LISP_EVAL_MUL_EN
  assign w_op_ok = (r_car == DATA_W'(0)) || (r_car == DATA_W'(1)) ||
                   (r_car == DATA_W'(2));
`else
  assign w_op_ok = (r_car == DATA_W'(0)) || (r_car == DATA_W'(1));
`endif

  // Fold the returned value into the top frame's accumulator.
  always_comb begin
    w_comb = r_acc[w_top];
    case (r_op[w_top])
      OP_ADD:  w_comb = r_acc[w_top] + r_val;
      OP_SUB:  w_comb = (r_argc[w_top] == 2'd0) ? r_val : (r_acc[w_top] - r_val);
`ifdef LISP_EVAL_MUL_EN
      OP_MUL:  w_comb = r_acc[w_top] * r_val;
`endif
      default: w_comb = r_acc[w_top];
    endcase
  end

  // Single-argument subtraction is negation.
  assign w_pop_val = ((r_op[w_top] == OP_SUB) && (r_argc[w_top] == 2'd1)) ?
                     (DATA_W'(0) - r_acc[w_top]) : r_acc[w_top];

  always_comb begin
    case (r_state)
      S_FETCH_CAR: o_mem_addr = r_cell - ADDR_W'(1);
      S_FETCH_CDR: o_mem_addr = r_cell - ADDR_W'(2);
      default:     o_mem_addr = r_cell;
    endcase
  end

  assign o_mem_req    = (r_state == S_FETCH_HDR) || (r_state == S_FETCH_CAR) ||
                        (r_state == S_FETCH_CDR);
  assign o_busy       = (r_state != S_IDLE) && (r_state != S_DONE) &&
                        (r_state != S_ERROR);
  assign o_done       = (r_state == S_DONE);
  assign o_err        = (r_state == S_ERROR);
  assign o_result     = r_result;
  assign o_error_code = r_err_code;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_ret      <= W_HDR;
      r_mode     <= M_EXPR;
      r_cell     <= '0;
      r_type     <= '0;
      r_car      <= '0;
      r_cdr      <= '0;
      r_val      <= '0;
      r_pend     <= '0;
      r_sp       <= '0;
      r_result   <= NIL;
      r_err_code <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cell  <= i_expr_in;
            r_mode  <= M_EXPR;
            r_sp    <= '0;
            r_state <= S_FETCH_HDR;
          end
        end
        S_FETCH_HDR: begin r_ret <= W_HDR; r_state <= S_MEM_WAIT; end
        S_FETCH_CAR: begin r_ret <= W_CAR; r_state <= S_MEM_WAIT; end
        S_FETCH_CDR: begin r_ret <= W_CDR; r_state <= S_MEM_WAIT; end
        S_MEM_WAIT: begin
          if (i_mem_ready) begin
            case (r_ret)
              W_HDR: begin r_type <= i_mem_data[DATA_W-2:0]; r_state <= S_FETCH_CAR; end
              W_CAR: begin r_car <= i_mem_data; r_state <= S_FETCH_CDR; end
              default: begin
                r_cdr <= i_mem_data;
                case (r_mode)
                  M_EXPR: r_state <= S_EVAL;
                  M_OP:   r_state <= S_APPLY;
                  default: begin
                    // Argument cell: advance the frame's list, evaluate the car.
                    r_args[w_top] <= i_mem_data;
                    r_cell        <= ADDR_W'(r_car);
                    r_mode        <= M_EXPR;
                    r_state       <= S_FETCH_HDR;
                  end
                endcase
              end
            endcase
          end
        end
        S_EVAL: begin
          if (w_is_num) begin
            r_val <= r_car;
            if (r_sp == '0) begin
              r_result <= r_car;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_RETURN;
            end
          end else if (w_is_cons) begin
            r_pend  <= r_cdr;
            r_cell  <= ADDR_W'(r_car);
            r_mode  <= M_OP;
            r_state <= S_FETCH_HDR;
          end else begin
            r_err_code <= lisp_defs::EVAL_ERROR;
            r_state    <= S_ERROR;
          end
        end
        S_APPLY: begin
          if (!w_is_prim || !w_op_ok) begin
            r_err_code <= lisp_defs::APPLY_ERROR;
            r_state    <= S_ERROR;
          end else if (r_sp == SP_W'(STACK_DEPTH)) begin
            r_err_code <= lisp_defs::STACK_ERROR;
            r_state    <= S_ERROR;
          end else begin
            r_op[w_push]   <= r_car[1:0];
            r_acc[w_push]  <= (r_car[1:0] == OP_MUL) ? DATA_W'(1) : DATA_W'(0);
            r_argc[w_push] <= 2'd0;
            r_args[w_push] <= r_pend;
            r_sp           <= r_sp + SP_W'(1);
            r_state        <= S_NEXT_ARG;
          end
        end
        S_NEXT_ARG: begin
          if (r_args[w_top] == NIL) begin
            if ((r_op[w_top] == OP_SUB) && (r_argc[w_top] == 2'd0)) begin
              r_err_code <= lisp_defs::APPLY_ERROR;
              r_state    <= S_ERROR;
            end else begin
              r_val   <= w_pop_val;
              r_sp    <= r_sp - SP_W'(1);
              r_state <= S_RETURN;
            end
          end else begin
            r_cell  <= ADDR_W'(r_args[w_top]);
            r_mode  <= M_ARG;
            r_state <= S_FETCH_HDR;
          end
        end
        S_RETURN: begin
          if (r_sp == '0) begin
            r_result <= r_val;
            r_state  <= S_DONE;
          end else begin
            r_acc[w_top]  <= w_comb;
            r_argc[w_top] <= (r_argc[w_top] == 2'd2) ? 2'd2 : (r_argc[w_top] + 2'd1);
            r_state       <= S_NEXT_ARG;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERROR: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lisp_eval_unit.sv
// Directed bench for lisp_eval_unit: builds expressions in a heap model,
// serves reads with configurable latency and checks results/error codes.
module tb_lisp_eval_unit;
  logic        clk = 1'b0;
  logic        rst, start, busy, done, err, mem_req, mem_ready;
  logic [15:0] expr, result, error_code, mem_addr, mem_data;

  always #5 clk = ~clk;

  lisp_eval_unit dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_expr_in(expr),
    .o_busy(busy), .o_done(done), .o_err(err), .o_result(result),
    .o_error_code(error_code), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_ready(mem_ready), .i_mem_data(mem_data)
  );

  localparam logic [15:0] T_NUM = 16'd1, T_CONS = 16'd2, T_PRIM = 16'd3;

  logic [15:0] mem [0:1023];
  int          checks = 0, errors = 0;
  int          req_cnt = 0, wait_cnt = 0, max_dly = 0;
  bit          rnd = 0;
  logic [15:0] req_log [0:7];
  logic [15:0] pend_addr, nxt;

  // Heap responder: ready arrives (1 + delay) negedges after the request.
  initial begin
    mem_ready = 1'b0; mem_data = '0; pend_addr = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          mem_ready = 1'b1;
          mem_data  = mem[pend_addr[9:0]];
        end
      end else if (mem_req) begin
        if (req_cnt < 8) req_log[req_cnt] = mem_addr;
        req_cnt++;
        pend_addr = mem_addr;
        wait_cnt  = 1 + (rnd ? int'($urandom_range(0, 5)) : max_dly);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mk(input logic [15:0] hdr, input logic [15:0] car,
                    input logic [15:0] cdr, output logic [15:0] a);
    logic [15:0] t;
    a = nxt + 16'd2;
    mem[a[9:0]] = hdr;
    t = a - 16'd1; mem[t[9:0]] = car;
    t = a - 16'd2; mem[t[9:0]] = cdr;
    nxt = nxt + 16'd3;
  endtask

  // Runs one request; returns at the negedge where done/err is observed.
  task automatic run(input logic [15:0] a, input bit poke, input logic [15:0] alt,
                     output logic [15:0] res, output logic [15:0] code,
                     output bit got_err, output int cyc);
    int k;
    @(negedge clk); start = 1'b1; expr = a; req_cnt = 0;
    @(negedge clk); start = 1'b0;
    k = 1;
    while (!(done || err) && k < 3000) begin
      if (poke && k == 3) begin
        check("busy_at_poke", busy, 1);
        start = 1'b1; expr = alt;
      end else start = 1'b0;
      @(negedge clk); k++;
    end
    start = 1'b0;
    if (!(done || err)) check("timeout", 0, 1);
    cyc = k; got_err = err; res = result; code = error_code;
  endtask

  logic [15:0] res, code;
  bit          ge;
  int          cyc;
  logic [15:0] p_add, p_sub, p_mul, p_bad, n1, n2, n3, n4, n5, n7, n55;
  logic [15:0] l1, l2, e_sub, e_add, e_neg, e_none, e_unk, e_nonprim, e_badop, e_mul;
  logic [15:0] e_nest, e_d8, e_d9;

  initial begin
    rst = 1'b1; start = 1'b0; expr = '0; nxt = 16'h0040;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_result", result, 16'h0000);
    check("rst_error_code", error_code, 16'h0000);
    rst = 1'b0;

    // Number at A=1: car at 0, cdr wraps to FFFF.
    mem[1] = T_NUM; mem[0] = 16'h002A; mem[1023] = 16'h0000;

    mk(T_PRIM, 16'd0, 16'd0, p_add);
    mk(T_PRIM, 16'd1, 16'd0, p_sub);
    mk(T_PRIM, 16'd2, 16'd0, p_mul);
    mk(T_PRIM, 16'd3, 16'd0, p_bad);
    mk(T_NUM, 16'd1, 16'd0, n1);
    mk(T_NUM, 16'd2, 16'd0, n2);
    mk(T_NUM, 16'd3, 16'd0, n3);
    mk(T_NUM, 16'd4, 16'd0, n4);
    mk(T_NUM, 16'd5, 16'd0, n5);
    mk(T_NUM, 16'd7, 16'd0, n7);
    mk(16'h8001, 16'h0055, 16'd0, n55);   // header MSB set, still a number
    // (- 5 2)
    mk(T_CONS, n2, 16'd0, l2); mk(T_CONS, n5, l2, l1); mk(T_CONS, p_sub, l1, e_sub);
    // (+ 1 (- 5 2))
    mk(T_CONS, e_sub, 16'd0, l2); mk(T_CONS, n1, l2, l1); mk(T_CONS, p_add, l1, e_add);
    // (- 3)
    mk(T_CONS, n3, 16'd0, l1); mk(T_CONS, p_sub, l1, e_neg);
    // (-)
    mk(T_CONS, p_sub, 16'd0, e_none);
    mk(16'h7FFF, 16'd0, 16'd0, e_unk);
    mk(T_CONS, n1, 16'd0, l1); mk(T_CONS, n1, l1, e_nonprim);
    mk(T_CONS, n1, 16'd0, l1); mk(T_CONS, p_bad, l1, e_badop);
    // (* 3 4)
    mk(T_CONS, n4, 16'd0, l2); mk(T_CONS, n3, l2, l1); mk(T_CONS, p_mul, l1, e_mul);
    // (+ (+ ... (+ 7))) nested 8 and 9 deep
    e_nest = n7; e_d8 = '0; e_d9 = '0;
    for (int d = 1; d <= 9; d++) begin
      mk(T_CONS, e_nest, 16'd0, l1);
      mk(T_CONS, p_add, l1, e_nest);
      if (d == 8) e_d8 = e_nest;
      if (d == 9) e_d9 = e_nest;
    end

    run(16'h0001, 0, 0, res, code, ge, cyc);
    check("num_err", ge, 0);
    check("num_done_cycle", cyc, 8);
    check("num_result", res, 16'h002A);
    check("num_req_count", req_cnt, 3);
    check("num_addr0", req_log[0], 16'h0001);
    check("num_addr1", req_log[1], 16'h0000);
    check("num_addr2", req_log[2], 16'hFFFF);

    // start during the done cycle must be ignored
    start = 1'b1; expr = 16'h0001;
    @(negedge clk); start = 1'b0;
    check("start_at_done_busy", busy, 0);
    @(negedge clk);
    check("start_at_done_idle", busy, 0);

    run(e_add, 0, 0, res, code, ge, cyc);
    check("add_sub_err", ge, 0);
    check("add_sub_result", res, 16'd4);

    rnd = 1'b1;
    for (int r = 0; r < 3; r++) begin
      run(e_add, 0, 0, res, code, ge, cyc);
      check("rand_dly_err", ge, 0);
      check("rand_dly_result", res, 16'd4);
    end
    rnd = 1'b0;

    run(e_neg, 0, 0, res, code, ge, cyc);
    check("neg_result", res, 16'hFFFD);
    run(e_none, 0, 0, res, code, ge, cyc);
    check("sub_noarg_err", ge, 1);
    check("sub_noarg_code", code, 16'hCCCC);
    run(e_d9, 0, 0, res, code, ge, cyc);
    check("depth9_err", ge, 1);
    check("depth9_code", code, 16'hDDDD);
    run(e_d8, 0, 0, res, code, ge, cyc);
    check("depth8_err", ge, 0);
    check("depth8_result", res, 16'd7);
    run(e_unk, 0, 0, res, code, ge, cyc);
    check("unk_type_err", ge, 1);
    check("unk_type_code", code, 16'hBBBB);
    run(n55, 0, 0, res, code, ge, cyc);
    check("hdr_msb_result", res, 16'h0055);
    run(e_nonprim, 0, 0, res, code, ge, cyc);
    check("nonprim_code", code, 16'hCCCC);
    run(e_badop, 0, 0, res, code, ge, cyc);
    check("badop_code", code, 16'hCCCC);
    run(e_mul, 0, 0, res, code, ge, cyc);
`ifdef LISP_EVAL_MUL_EN
    check("mul_err", ge, 0);
    check("mul_result", res, 16'd12);
`else
    check("mul_err", ge, 1);
    check("mul_code", code, 16'hCCCC);
`endif

    // Reset during MemWait with a late ready
    max_dly = 5;
    @(negedge clk); start = 1'b1; expr = e_add;
    @(negedge clk); start = 1'b0;
    begin
      int k;
      k = 0;
      while (!mem_req && k < 20) begin @(negedge clk); k++; end
      if (!mem_req) check("rst_wait_req", 0, 1);
    end
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_addr", mem_addr, 16'h0000);
    check("mid_rst_result", result, 16'h0000);
    begin
      bit act;
      act = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (busy || done || err || mem_req) act = 1'b1;
      end
      check("late_ready_ignored", act, 0);
    end
    max_dly = 0;
    run(e_add, 1, e_unk, res, code, ge, cyc);
    check("after_rst_err", ge, 0);
    check("after_rst_result", res, 16'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lisp_eval_unit.md
# lisp_eval_unit

Parametrised successor to the single-shot number evaluator in the Lisp machine core. Walks heap cells through a request/ready memory port and evaluates number atoms and nested primitive applications (`+`, `-`, optionally `*`) using an internal frame stack. Sits between the front-panel/top-level sequencer (which supplies an expression pointer and a start pulse) and the heap memory. Returns one result word or an error code per request.

## Interface
- `DATA_W`, 16: heap word width and result width; must be ≥ 16.
- `ADDR_W`, 16: heap address width.
- `STACK_DEPTH`, 8: maximum nesting depth of pending applications.

- `clk`  input  1  clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  single-cycle request; sampled only in `Idle`.
- `expr_in`  input  ADDR_W  pointer to the expression cell header.
- `busy`  output  1  high from the cycle after `start` is accepted until `done`/`err`.
- `done`  output  1  one-cycle pulse; `result` is valid.
- `err`  output  1  one-cycle pulse; `error_code` is valid.
- `result`  output  DATA_W  last value; held until the next accepted `start`.
- `error_code`  output  16  last error; held until the next accepted `start`.
- `mem_req`  output  1  one-cycle read request.
- `mem_addr`  output  ADDR_W  read address, valid with `mem_req`.
- `mem_ready`  input  1  one-cycle pulse; `mem_data` is valid.
- `mem_data`  input  DATA_W  read data.

## Operation
- Cell at address A: header at A, car at A−1, cdr at A−2. Addresses wrap modulo 2^ADDR_W. Type field is `header[DATA_W-2:0]`; the MSB is ignored.
- States: `Idle`, `FetchHeader`, `FetchCar`, `FetchCdr`, `MemWait`, `Eval`, `Apply`, `NextArg`, `Return`, `Done`, `Error`.
- `MemWait` holds the return state. It leaves only on `mem_ready` and captures `mem_data` into the header, car or cdr register.
- `Eval` dispatches on the type field:
  - `lisp_defs::TYPE_NUMBER`: value = car.
  - `lisp_defs::TYPE_CONS`: car must point to a `TYPE_PRIMITIVE` cell whose car is the opcode (0 ADD, 1 SUB, 2 MUL). Push frame {op, acc, argc, arg list = cdr} and evaluate the arguments left to right.
  - Any other type: `EVAL_ERROR` (16'hBBBB).
- Argument combination, modulo 2^DATA_W:
  - ADD: acc starts at 0.
  - SUB: first argument loads acc; later arguments subtract. A single argument negates (0 − a). Zero arguments give `APPLY_ERROR` (16'hCCCC).
  - MUL: acc starts at 1.
- The argument list ends when cdr == `lisp_defs::LISP_NIL`. The frame then pops and acc becomes the value returned to the parent frame, or the final result if the stack is empty.
- Non-primitive operator or an unknown opcode: `APPLY_ERROR`.
- Push with STACK_DEPTH frames already live: `STACK_ERROR` (16'hDDDD).
- The `Error` state pulses `err`, then returns to `Idle`. `Done` pulses `done`, then returns to `Idle`.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `mem_req`=0, `mem_addr`=0, `result`=`LISP_NIL`, `error_code`=0, stack empty, state `Idle`.
- Each cell costs 3 reads. Each read is one `mem_req` cycle followed by ≥1 `MemWait` cycle.
- Number atom, with `mem_ready` one cycle after `mem_req`: `start` is sampled at edge 0 and `done` is high in cycle 8.
- `mem_ready` arriving outside `MemWait` is ignored. `mem_req` is never reasserted before the previous ready is received.
- `start` while `busy` is ignored. `start` in the same cycle as `done`/`err` is ignored. It is accepted on the following cycle.
- `rst` mid-operation: return to `Idle` on the next edge and clear the stack. A late `mem_ready` after reset is ignored.

## Configuration
- `LISP_EVAL_MUL_EN`:
  - Defined: opcode 2 performs multiplication, truncated to DATA_W.
  - Undefined: no multiplier is synthesised, and opcode 2 raises `APPLY_ERROR`.

## Test plan
- Number cell, car=16'h002A, 1-cycle-ready memory → `done` in cycle 8, `result`=16'h002A, exactly 3 `mem_req` pulses at addresses A, A−1, A−2.
- (+ 1 (- 5 2)) → `result`=4. Random 0–5 cycle `mem_ready` delays give the same result.
- (- 3) → 16'hFFFD; (-) with no arguments → `err` with `error_code`=16'hCCCC.
- Nesting of depth STACK_DEPTH+1 → `err` with 16'hDDDD. Depth STACK_DEPTH → correct result.
- Unknown type header 16'h7FFF → 16'hBBBB. (* 3 4) → 12 with `LISP_EVAL_MUL_EN` defined, 16'hCCCC without it.
- `rst` asserted during `MemWait` with a late `mem_ready` → idle outputs. Next `start` evaluates correctly. `start` pulses while `busy` have no effect.
